// File: rtl/ts_packet_arbiter.sv
// ts_packet_arbiter: whole-packet round-robin arbiter sharing one TS byte lane
// between N_IN sync-recovered input streams.
// Optional statistics counters (pkt_cnt, drop_cnt) are enabled by defining
// TS_ARB_STATS_EN; without it those ports and their logic are absent.
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | no packet in flight; pick next header, drop stray non-header bytes
// XFER  | forwarding bytes of packet from grant_id until last byte or early sync
module ts_packet_arbiter #(
  parameter int N_IN    = 4,
  parameter int PKT_LEN = 188
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN-1:0]          in_sync,
  input  logic [8*N_IN-1:0]        in_byte,
  output logic [N_IN-1:0]          in_ready,
  output logic                     out_valid,
  output logic                     out_sync,
  output logic [7:0]               out_byte,
  input  logic                     out_ready,
  output logic [$clog2(N_IN)-1:0]  grant_id,
  output logic                     pkt_err
`ifdef TS_ARB_STATS_EN
  ,
  output logic [31:0]              pkt_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int GW = $clog2(N_IN);
  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

  typedef enum logic {ARB, XFER} state_t;

  state_t          state_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_q;
  logic            out_valid_q;
  logic            out_sync_q;
  logic [7:0]      out_byte_q;
  logic            pkt_err_q;

  logic            space;
  logic [N_IN-1:0] req;
  logic [N_IN-1:0] stray;
  logic            g_valid;
  logic            g_sync;
  logic [7:0]      g_byte;
  logic            early_sync;
  logic            xfer;
  logic            rr_found;
  logic [GW-1:0]   rr_pick;
  int              rr_idx;

  // Granted-input mux, round-robin search and handshake decode.
  always_comb begin
    space   = !out_valid_q || out_ready;
    req     = in_valid & in_sync;
    stray   = in_valid & ~in_sync;
    g_valid = 1'b0;
    g_sync  = 1'b0;
    g_byte  = 8'h00;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = in_valid[i];
        g_sync  = in_sync[i];
        g_byte  = in_byte[8*i +: 8];
      end
    end
    // A header arriving mid-packet means the current packet was cut short.
    early_sync = g_sync && (byte_cnt_q != '0);
    xfer       = (state_q == XFER) && g_valid && space && !early_sync;

    rr_found = 1'b0;
    rr_pick  = ptr_q;
    rr_idx   = 0;
    for (int k = 1; k <= N_IN; k++) begin
      rr_idx = (int'(ptr_q) + k) % N_IN;
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = GW'(rr_idx);
      end
    end
  end

  // Per-input accept: stray discard while idle, granted input only while busy.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (state_q == ARB) begin
        in_ready = stray;
      end else begin
        for (int i = 0; i < N_IN; i++) begin
          if (grant_q == GW'(i)) in_ready[i] = space && !early_sync;
        end
      end
    end
  end

  // Arbitration FSM with registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      byte_cnt_q  <= '0;
      ptr_q       <= GW'(N_IN - 1);
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_byte_q  <= 8'h00;
      pkt_err_q   <= 1'b0;
    end else begin
      pkt_err_q <= 1'b0;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= g_byte;
        out_sync_q  <= (byte_cnt_q == '0);
      end else if (space) begin
        out_valid_q <= 1'b0;
        out_sync_q  <= 1'b0;
      end
      case (state_q)
        ARB: begin
          if (rr_found) begin
            grant_q    <= rr_pick;
            ptr_q      <= rr_pick;
            byte_cnt_q <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            if (byte_cnt_q == LAST_IDX) begin
              byte_cnt_q <= '0;
              state_q    <= ARB;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end else if (g_valid && early_sync) begin
            // Header is left in place so it re-enters arbitration as a request.
            pkt_err_q <= 1'b1;
            state_q   <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign out_byte  = out_byte_q;
  assign grant_id  = grant_q;
  assign pkt_err   = pkt_err_q;

`ifdef TS_ARB_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  // Several inputs can shed a stray byte in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    if (state_q == ARB) drop_sum = {1'b0, drop_cnt_q} + 17'($countones(in_valid & in_ready));
  end

  // Completed-packet counter wraps; drop counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (xfer && (byte_cnt_q == LAST_IDX)) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Testbench for ts_packet_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ts_packet_arbiter;
  localparam int N  = 4;
  localparam int PL = 188;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid, in_sync, in_ready;
  logic [8*N-1:0] in_byte;
  logic           out_valid, out_sync, out_ready, pkt_err;
  logic [7:0]     out_byte;
  logic [1:0]     grant_id;
`ifdef TS_ARB_STATS_EN
  logic [31:0]    pkt_cnt;
  logic [15:0]    drop_cnt;
`endif

  ts_packet_arbiter #(.N_IN(N), .PKT_LEN(PL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sync(in_sync), .in_byte(in_byte), .in_ready(in_ready),
    .out_valid(out_valid), .out_sync(out_sync), .out_byte(out_byte), .out_ready(out_ready),
    .grant_id(grant_id), .pkt_err(pkt_err)
`ifdef TS_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;

  // Source FIFOs: bit 8 = sync marker, bits 7:0 = data.
  logic [8:0] srcq [N][$];
  int   vpct [N];
  int   rpct;
  bit   hold_ready;

  logic [7:0] exp_bytes[$];
  logic [7:0] obs_bytes[$];
  logic [7:0] obs_sync_bytes[$];
  int         obs_order[$];
  bit         ov_trace[$];
  int         acc_cnt [N];
  int         obs_err;

  // Reference model: "is a packet in flight, from whom, how far along".
  bit         m_busy;
  int         m_g, m_cnt, m_ptr, m_grant;
  bit         m_ov, m_os, m_err;
  logic [7:0] m_ob;
  int         m_drop;
  longint     m_pkts;

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = N - 1; m_grant = 0;
    m_ov = 0; m_os = 0; m_ob = 8'h00; m_err = 0; m_drop = 0; m_pkts = 0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst) return r;
    if (!m_busy) begin
      for (int i = 0; i < N; i++) r[i] = in_valid[i] && !in_sync[i];
    end else begin
      r[m_g] = (!m_ov || out_ready) && !(in_sync[m_g] && m_cnt != 0);
    end
    return r;
  endfunction

  task automatic model_update(input logic [N-1:0] rdy);
    bit space;
    bit found;
    int idx;
    space = !m_ov || out_ready;
    if (rst) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (m_busy) begin
      if (in_valid[m_g] && rdy[m_g]) begin
        m_ov = 1; m_ob = in_byte[8*m_g +: 8]; m_os = (m_cnt == 0);
        if (m_cnt == PL - 1) begin m_busy = 0; m_pkts++; m_cnt = 0; end
        else m_cnt++;
      end else begin
        if (space) begin m_ov = 0; m_os = 0; end
        if (in_valid[m_g] && in_sync[m_g] && m_cnt != 0) begin m_err = 1; m_busy = 0; end
      end
    end else begin
      if (space) begin m_ov = 0; m_os = 0; end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && !in_sync[i] && m_drop < 65535) m_drop++;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && in_valid[idx] && in_sync[idx]) begin
          found = 1; m_g = idx; m_grant = idx; m_ptr = idx; m_cnt = 0; m_busy = 1;
        end
      end
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && $urandom_range(99) < vpct[i]) begin
        h = srcq[i][0];
        in_valid[i] = 1'b1; in_sync[i] = h[8]; in_byte[8*i +: 8] = h[7:0];
      end else begin
        in_valid[i] = 1'b0; in_sync[i] = 1'($urandom_range(1)); in_byte[8*i +: 8] = 8'($urandom);
      end
    end
    out_ready = hold_ready ? 1'b0 : ($urandom_range(99) < rpct);
  endtask

  // One clock: drive, compare DUT against model at negedge, advance model at posedge.
  task automatic tick();
    logic [N-1:0] rdy;
    drive_inputs();
    @(negedge clk);
    rdy = exp_ready();
    checks += 6;
    if (in_ready !== rdy) begin fails++; $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, rdy); end
    if (out_valid !== m_ov) begin fails++; $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, m_ov); end
    if (out_sync !== m_os) begin fails++; $display("FAIL out_sync t=%0t got %b exp %b", $time, out_sync, m_os); end
    if (out_byte !== m_ob) begin fails++; $display("FAIL out_byte t=%0t got %h exp %h", $time, out_byte, m_ob); end
    if (grant_id !== 2'(m_grant)) begin fails++; $display("FAIL grant_id t=%0t got %0d exp %0d", $time, grant_id, m_grant); end
    if (pkt_err !== m_err) begin fails++; $display("FAIL pkt_err t=%0t got %b exp %b", $time, pkt_err, m_err); end
`ifdef TS_ARB_STATS_EN
    checks += 2;
    if (drop_cnt !== 16'(m_drop)) begin fails++; $display("FAIL drop_cnt t=%0t got %0d exp %0d", $time, drop_cnt, m_drop); end
    if (pkt_cnt !== 32'(m_pkts)) begin fails++; $display("FAIL pkt_cnt t=%0t got %0d exp %0d", $time, pkt_cnt, m_pkts); end
`endif
    ov_trace.push_back(out_valid);
    if (out_valid && out_ready) begin
      obs_bytes.push_back(out_byte);
      if (out_sync) begin obs_order.push_back(int'(grant_id)); obs_sync_bytes.push_back(out_byte); end
    end
    if (pkt_err) obs_err++;
    for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) acc_cnt[i]++;
    @(posedge clk);
    model_update(rdy);
    for (int i = 0; i < N; i++) if (rdy[i] && in_valid[i]) void'(srcq[i].pop_front());
    #1;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 0;
    return !m_busy && !m_ov;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin fails++; $display("FAIL %s timeout after %0d cycles, need idle", name, n); end
    tick(); tick();
  endtask

  task automatic add_pkt(input int i, input int len, input bit to_exp);
    logic [7:0] b;
    srcq[i].push_back({1'b1, 8'h47});
    if (to_exp) exp_bytes.push_back(8'h47);
    for (int k = 1; k < len; k++) begin
      b = 8'($urandom);
      srcq[i].push_back({1'b0, b});
      if (to_exp) exp_bytes.push_back(b);
    end
  endtask

  task automatic clear_logs();
    exp_bytes.delete(); obs_bytes.delete(); obs_sync_bytes.delete();
    obs_order.delete(); ov_trace.delete(); obs_err = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; hold_ready = 0; rpct = 100;
    for (int i = 0; i < N; i++) begin srcq[i].delete(); vpct[i] = 100; end
    tick(); tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1; hold_ready = 0; rpct = 100;
    in_valid = '0; in_sync = '0; in_byte = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin srcq[i].delete(); vpct[i] = 100; end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    clear_logs();
    for (int k = 0; k < 3; k++) srcq[1].push_back({1'b0, 8'(8'h10 + k)});
    tick(); tick();
    checks += 6;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_sync !== 1'b0) begin fails++; $display("FAIL reset_out_sync got %b exp 0", out_sync); end
    if (out_byte !== 8'h00) begin fails++; $display("FAIL reset_out_byte got %h exp 00", out_byte); end
    if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    if (pkt_err !== 1'b0) begin fails++; $display("FAIL reset_pkt_err got %b exp 0", pkt_err); end
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin fails++; $display("FAIL release_stray_ready got %b exp 0010", in_ready); end
    run_until_idle(100, "reset_drain");
  endtask

  task automatic test_single();
    int bad;
    apply_reset();
    srcq[2].push_back({1'b1, 8'h47}); exp_bytes.push_back(8'h47);
    for (int k = 1; k < PL; k++) begin srcq[2].push_back({1'b0, 8'(k)}); exp_bytes.push_back(8'(k)); end
    run_until_idle(1000, "single");
    bad = 0;
    for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++) if (obs_bytes[k] !== exp_bytes[k]) bad++;
    checks += 4;
    if (obs_bytes.size() != PL || bad != 0) begin fails++; $display("FAIL single_stream got %0d beats %0d bad exp %0d beats", obs_bytes.size(), bad, PL); end
    if (obs_order.size() != 1 || obs_order[0] != 2) begin fails++; $display("FAIL single_grant got %0d pkts exp 1 pkt from input 2", obs_order.size()); end
    if (obs_sync_bytes.size() != 1 || obs_sync_bytes[0] !== 8'h47) begin fails++; $display("FAIL single_sync got %0d sync beats exp 1 on 47", obs_sync_bytes.size()); end
    srcq[1].push_back({1'b0, 8'hAA});
    tick();
    if (acc_cnt[1] != 1) begin fails++; $display("FAIL single_back_to_arb got %0d stray accepts exp 1", acc_cnt[1]); end
  endtask

  task automatic test_all4();
    int bad, first, last, gaps;
    apply_reset();
    add_pkt(0, PL, 1); add_pkt(1, PL, 1); add_pkt(2, PL, 1); add_pkt(3, PL, 1); add_pkt(0, PL, 1);
    run_until_idle(3000, "all4");
    bad = 0;
    for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++) if (obs_bytes[k] !== exp_bytes[k]) bad++;
    checks += 3;
    if (obs_bytes.size() != 5*PL || bad != 0) begin fails++; $display("FAIL all4_stream got %0d beats %0d bad exp %0d", obs_bytes.size(), bad, 5*PL); end
    if (obs_order.size() != 5 || obs_order[0] != 0 || obs_order[1] != 1 || obs_order[2] != 2 ||
        obs_order[3] != 3 || obs_order[4] != 0) begin
      fails++; $display("FAIL all4_order got %p exp '{0,1,2,3,0}", obs_order);
    end
    first = -1; last = -1; gaps = 0;
    foreach (ov_trace[k]) if (ov_trace[k]) begin if (first < 0) first = k; last = k; end
    for (int k = first; k <= last && first >= 0; k++) if (!ov_trace[k]) gaps++;
    if (gaps != 4) begin fails++; $display("FAIL all4_gaps got %0d idle cycles exp 4", gaps); end
  endtask

  task automatic test_trunc();
    int bad;
    apply_reset();
    add_pkt(1, 100, 1);
    add_pkt(2, PL, 1);
    add_pkt(1, PL, 1);
    run_until_idle(3000, "trunc");
    bad = 0;
    for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++) if (obs_bytes[k] !== exp_bytes[k]) bad++;
    checks += 3;
    if (obs_bytes.size() != 100 + 2*PL || bad != 0) begin fails++; $display("FAIL trunc_stream got %0d beats %0d bad exp %0d", obs_bytes.size(), bad, 100 + 2*PL); end
    if (obs_order.size() != 3 || obs_order[0] != 1 || obs_order[1] != 2 || obs_order[2] != 1) begin
      fails++; $display("FAIL trunc_order got %p exp '{1,2,1}", obs_order);
    end
    if (obs_err != 1) begin fails++; $display("FAIL trunc_err_pulse got %0d cycles exp 1", obs_err); end
  endtask

  task automatic test_backpressure();
    int n, bad;
    apply_reset();
    add_pkt(0, PL, 1);
    n = 0;
    while (obs_bytes.size() < 50 && n < 500) begin tick(); n++; end
    checks++;
    if (n >= 500) begin fails++; $display("FAIL bp_reach50 timeout got %0d beats exp 50", obs_bytes.size()); end
    hold_ready = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, out_valid); end
      if (out_byte !== exp_bytes[50]) begin fails++; $display("FAIL bp_byte cyc %0d got %h exp %h", c, out_byte, exp_bytes[50]); end
      if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", c, in_ready[0]); end
    end
    hold_ready = 0;
    run_until_idle(1000, "bp");
    bad = 0;
    for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++) if (obs_bytes[k] !== exp_bytes[k]) bad++;
    checks++;
    if (obs_bytes.size() != PL || bad != 0) begin fails++; $display("FAIL bp_stream got %0d beats %0d bad exp %0d", obs_bytes.size(), bad, PL); end
  endtask

  task automatic test_stray();
    apply_reset();
    for (int k = 0; k < 10; k++) srcq[3].push_back({1'b0, 8'(8'h30 + k)});
    repeat (10) tick();
    tick();
    checks += 2;
    if (acc_cnt[3] != 10) begin fails++; $display("FAIL stray_accept got %0d exp 10", acc_cnt[3]); end
    if (obs_bytes.size() != 0) begin fails++; $display("FAIL stray_output got %0d beats exp 0", obs_bytes.size()); end
`ifdef TS_ARB_STATS_EN
    checks++;
    if (drop_cnt !== 16'd10) begin fails++; $display("FAIL stray_drop_cnt got %0d exp 10", drop_cnt); end
`endif
  endtask

  task automatic test_rst_mid();
    int n;
    apply_reset();
    add_pkt(2, PL, 0);
    n = 0;
    while (obs_bytes.size() < 50 && n < 500) begin tick(); n++; end
    add_pkt(0, PL, 0);
    rst = 1'b1;
    tick();
    checks += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    if (grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_grant got %0d exp 0", grant_id); end
    if (pkt_err !== 1'b0) begin fails++; $display("FAIL rstmid_pkt_err got %b exp 0", pkt_err); end
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_in_ready got %b exp 0000", in_ready); end
    rst = 1'b0;
    obs_order.delete(); obs_err = 0;
    run_until_idle(2000, "rstmid");
    checks += 2;
    if (obs_order.size() != 1 || obs_order[0] != 0) begin fails++; $display("FAIL rstmid_first_grant got %p exp '{0}", obs_order); end
    if (obs_err != 0) begin fails++; $display("FAIL rstmid_err got %0d exp 0", obs_err); end
  endtask

  task automatic test_random(input int rp);
    int npk, ntr, nfwd, np, len;
    bit tr;
    apply_reset();
    npk = 0; ntr = 0; nfwd = 0;
    for (int i = 0; i < N; i++) begin
      vpct[i] = $urandom_range(100, 50);
      repeat ($urandom_range(3)) srcq[i].push_back({1'b0, 8'($urandom)});
      np = $urandom_range(3, 1);
      for (int p = 0; p < np; p++) begin
        tr  = (p != np - 1) && ($urandom_range(2) == 0);
        len = tr ? $urandom_range(PL - 1, 1) : PL;
        add_pkt(i, len, 0);
        npk++; nfwd += len;
        if (tr) ntr++;
        else if (p != np - 1) repeat ($urandom_range(2)) srcq[i].push_back({1'b0, 8'($urandom)});
      end
    end
    rpct = rp;
    run_until_idle(30000, "random");
    checks += 3;
    if (obs_err != ntr) begin fails++; $display("FAIL rand_err_count got %0d exp %0d", obs_err, ntr); end
    if (obs_order.size() != npk) begin fails++; $display("FAIL rand_pkt_count got %0d exp %0d", obs_order.size(), npk); end
    if (obs_bytes.size() != nfwd) begin fails++; $display("FAIL rand_byte_count got %0d exp %0d", obs_bytes.size(), nfwd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_trunc();
    test_backpressure();
    test_stray();
    test_rst_mid();
    test_random(70);
    test_random(95);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ts_packet_arbiter.md
Name: ts_packet_arbiter

Overview:
- Shares one TS output byte lane between N_IN sync-recovered input streams; whole-packet granularity, round-robin.
- Sits downstream of per-channel sync recovery and per-channel FIFOs; feeds the single QoS/analysis path.
- Never interleaves bytes of two packets.
- Discards stray non-header bytes on idle inputs so no input can deadlock the scheduler.

Parameters:
- N_IN, 4, number of requesting input streams (2..8).
- PKT_LEN, 188, bytes per TS packet.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  N_IN  per-input byte valid
- in_sync  input  N_IN  per-input marker: byte is first byte (0x47) of a packet
- in_byte  input  8*N_IN  per-input data; input i occupies bits [8i+7:8i]
- in_ready  output  N_IN  per-input accept; combinational from state/inputs
- out_valid  output  1  output byte valid (registered)
- out_sync  output  1  high with first byte of each forwarded packet (registered)
- out_byte  output  8  forwarded byte (registered)
- out_ready  input  1  downstream accept
- grant_id  output  $clog2(N_IN)  currently or last granted input (registered)
- pkt_err  output  1  one-cycle pulse: granted packet truncated by early in_sync

Behaviour:
- Reset values: out_valid=0, out_sync=0, out_byte=0, grant_id=0, pkt_err=0, state=ARB, byte_cnt=0, RR pointer=N_IN-1 (input 0 has highest priority first); in_ready forced 0 while rst=1.
- rst asserted mid-packet: packet abandoned, no pkt_err, all of the above restored next edge.
- Output stage: space = !out_valid || out_ready. A transfer occurs when in_valid[g] && in_ready[g]. On a transfer: out_valid<=1, out_byte<=in_byte[g], out_sync<=(byte_cnt==0). If space and no transfer: out_valid<=0, out_sync<=0. Latency 1 cycle, input to output.
- Request: req[i] = in_valid[i] && in_sync[i].
- State ARB:
  - Pick the first req[i] scanning from pointer+1 with wrap-around.
  - If found: grant_id<=i, pointer<=i, byte_cnt<=0, go to XFER. No byte is consumed in ARB.
  - If none: stay in ARB.
  - in_ready[i]=1 for every i with in_valid[i] && !in_sync[i] (stray-byte discard); otherwise 0.
- State XFER, with g=grant_id:
  - in_ready[g] = space && !(in_sync[g] && byte_cnt!=0); in_ready of all other inputs = 0.
  - Each transfer increments byte_cnt.
  - Transfer with byte_cnt==PKT_LEN-1: go to ARB. Minimum 1-cycle gap between packets.
  - in_valid[g] && in_sync[g] && byte_cnt!=0: that byte is not consumed, pkt_err pulses 1 cycle, go to ARB. The byte remains a valid header request.
- Simultaneous requests: strict round-robin. Just-served input has lowest priority in the next ARB.
- Backpressure (out_ready=0 with out_valid=1): out_* held stable, no transfer, byte_cnt frozen.
- byte_cnt width: $clog2(PKT_LEN). Never exceeds PKT_LEN-1.

Optional Feature:
- Macro TS_ARB_STATS_EN.
- Defined: adds output pkt_cnt (32 bit) and output drop_cnt (16 bit). Both reset to 0.
  - pkt_cnt increments on each completed packet (last-byte transfer) and wraps at 2^32.
  - drop_cnt increments per discarded stray byte and saturates at 0xFFFF.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- Single requester: input 2 sends 188 bytes (0x47, 0x01..0xBB), out_ready=1 -> grant_id=2; out_sync=1 only on 0x47; 188 out_valid cycles, each 1 cycle after its in_ready transfer; back to ARB.
- All 4 inputs hold headers after reset -> packets forwarded in order 0,1,2,3,0; ARB gap of exactly 1 cycle each; never interleaved.
- Truncation: input 1 granted, asserts in_sync at byte 100 -> 100 bytes forwarded, pkt_err=1 for 1 cycle, header byte not consumed; input 1 re-granted only after other pending requesters.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_byte/out_valid stable, in_ready[g]=0, byte_cnt unchanged; resume with no loss or duplication.
- Stray bytes: input 3 presents 10 non-sync bytes while in ARB -> all 10 accepted and dropped, nothing on out, drop_cnt=10 (with TS_ARB_STATS_EN).
- rst=1 at byte 50 of a packet -> next cycle out_valid=0, grant_id=0, pkt_err=0, in_ready=0; after release, input 0 wins first arbitration.
